// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU opcodes, flag bit
// positions within rsp_flags, and the arbiter state encoding.
package alu_pkg;
   localparam int WIDTH_DEF  = 32;
   localparam int ALUC_W_DEF = 4;

   localparam logic [3:0] ALUC_ADDU = 4'b0000;
   localparam logic [3:0] ALUC_SUBU = 4'b0001;
   localparam logic [3:0] ALUC_ADD  = 4'b0010;
   localparam logic [3:0] ALUC_SUB  = 4'b0011;
   localparam logic [3:0] ALUC_AND  = 4'b0100;
   localparam logic [3:0] ALUC_OR   = 4'b0101;
   localparam logic [3:0] ALUC_XOR  = 4'b0110;
   localparam logic [3:0] ALUC_NOR  = 4'b0111;
   localparam logic [3:0] ALUC_LUI  = 4'b1000;
   localparam logic [3:0] ALUC_SLTU = 4'b1010;
   localparam logic [3:0] ALUC_SLT  = 4'b1011;
   localparam logic [3:0] ALUC_SRA  = 4'b1100;
   localparam logic [3:0] ALUC_SRL  = 4'b1101;
   localparam logic [3:0] ALUC_SLL  = 4'b1110;

   // rsp_flags = {zero, carry, negative, overflow}
   localparam int FLAG_ZERO  = 3;
   localparam int FLAG_CARRY = 2;
   localparam int FLAG_NEG   = 1;
   localparam int FLAG_OVF   = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;
endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters and the ALU arbiter.
interface alu_share_arbiter_if #(
   parameter int WIDTH  = 32,
   parameter int ALUC_W = 4
);
   logic              req0_valid, req0_ready;
   logic [WIDTH-1:0]  req0_a, req0_b;
   logic [ALUC_W-1:0] req0_aluc;
   logic              req1_valid, req1_ready;
   logic [WIDTH-1:0]  req1_a, req1_b;
   logic [ALUC_W-1:0] req1_aluc;
   logic              rsp0_valid, rsp0_ready;
   logic              rsp1_valid, rsp1_ready;
   logic [WIDTH-1:0]  rsp_r;
   logic [3:0]        rsp_flags;

   modport master (
      output req0_valid, req0_a, req0_b, req0_aluc,
      output req1_valid, req1_a, req1_b, req1_aluc,
      output rsp0_ready, rsp1_ready,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_r, rsp_flags
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_aluc,
      input  req1_valid, req1_a, req1_b, req1_aluc,
      input  rsp0_ready, rsp1_ready,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_r, rsp_flags
   );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to prio_i.
module rr_arb2 (
   input  logic valid0_i,
   input  logic valid1_i,
   input  logic prio_i,
   output logic grant0_o,
   output logic grant1_o
);
   assign grant0_o = valid0_i & (~valid1_i | ~prio_i);
   assign grant1_o = valid1_i & (~valid0_i |  prio_i);
endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational ALU between two requesters.
// Operands are registered on grant, result/flags registered after one EXEC cycle.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int ALUC_W    = 4,
   parameter bit INIT_PRIO = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   alu_share_arbiter_if.slave bus,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   output logic [ALUC_W-1:0]  alu_aluc,
   input  logic [WIDTH-1:0]   alu_r,
   input  logic               alu_zero,
   input  logic               alu_carry,
   input  logic               alu_negative,
   input  logic               alu_overflow
);
   state_t            state_q, state_d;
   logic [WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
   logic [ALUC_W-1:0] op_aluc_q, op_aluc_d;
   logic              owner_q, owner_d, prio_q, prio_d;
   logic [WIDTH-1:0]  rsp_r_q, rsp_r_d;
   logic [3:0]        rsp_flags_q, rsp_flags_d;

   logic owner_rsp_ready, grant_win, gnt0, gnt1, grant;

   rr_arb2 u_arb (
      .valid0_i (bus.req0_valid),
      .valid1_i (bus.req1_valid),
      .prio_i   (prio_q),
      .grant0_o (gnt0),
      .grant1_o (gnt1)
   );

   // Grants open in IDLE, or in RESP on the very cycle the owner drains its result.
   assign owner_rsp_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
   assign grant_win = ~rst & ~flush &
                      ((state_q == ST_IDLE) | ((state_q == ST_RESP) & owner_rsp_ready));
   assign grant = grant_win & (gnt0 | gnt1);

   assign bus.req0_ready = grant_win & gnt0;
   assign bus.req1_ready = grant_win & gnt1;
   assign bus.rsp0_valid = (state_q == ST_RESP) & ~owner_q;
   assign bus.rsp1_valid = (state_q == ST_RESP) &  owner_q;
   assign bus.rsp_r      = rsp_r_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign alu_a          = op_a_q;
   assign alu_b          = op_b_q;
   assign alu_aluc       = op_aluc_q;

   always_comb begin
      state_d     = state_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_aluc_d   = op_aluc_q;
      owner_d     = owner_q;
      prio_d      = prio_q;
      rsp_r_d     = rsp_r_q;
      rsp_flags_d = rsp_flags_q;

      case (state_q)
         ST_IDLE: if (grant) state_d = ST_EXEC;
         ST_EXEC: begin
            state_d     = ST_RESP;
            rsp_r_d     = alu_r;
            rsp_flags_d = {alu_zero, alu_carry, alu_negative, alu_overflow};
         end
         ST_RESP: if (owner_rsp_ready) state_d = grant ? ST_EXEC : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (grant) begin
         op_a_d    = gnt1 ? bus.req1_a    : bus.req0_a;
         op_b_d    = gnt1 ? bus.req1_b    : bus.req0_b;
         op_aluc_d = gnt1 ? bus.req1_aluc : bus.req0_aluc;
         owner_d   = gnt1;
         prio_d    = ~gnt1;
      end

      if (flush) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_aluc_q   <= '0;
         owner_q     <= 1'b0;
         prio_q      <= INIT_PRIO;
         rsp_r_q     <= '0;
         rsp_flags_q <= '0;
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_aluc_q   <= op_aluc_d;
         owner_q     <= owner_d;
         prio_q      <= prio_d;
         rsp_r_q     <= rsp_r_d;
         rsp_flags_q <= rsp_flags_d;
      end
   end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU plus a transaction-level
// model of grant/response timing, checked every cycle, with directed scenarios.
module tb_alu_share_arbiter;
   import alu_pkg::*;

   localparam bit INIT_PRIO = 1'b0;

   logic        clk, rst, flush;
   logic [31:0] alu_a, alu_b, alu_r;
   logic [3:0]  alu_aluc;
   logic        alu_zero, alu_carry, alu_negative, alu_overflow;
   int          checks = 0;
   int          errors = 0;

   alu_share_arbiter_if #(.WIDTH(32), .ALUC_W(4)) bus ();

   alu_share_arbiter #(.WIDTH(32), .ALUC_W(4), .INIT_PRIO(INIT_PRIO)) dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus),
      .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r),
      .alu_zero(alu_zero), .alu_carry(alu_carry),
      .alu_negative(alu_negative), .alu_overflow(alu_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: returns {zero, carry, negative, overflow, result}.
   function automatic logic [35:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [3:0] op);
      logic [32:0] s;
      logic [31:0] r;
      logic c, v;
      s = '0; r = '0; c = 1'b0; v = 1'b0;
      case (op)
         ALUC_ADDU, ALUC_ADD: begin
            s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         ALUC_SUBU, ALUC_SUB: begin
            s = {1'b0, a} - {1'b0, b}; r = s[31:0]; c = s[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         ALUC_AND:  r = a & b;
         ALUC_OR:   r = a | b;
         ALUC_XOR:  r = a ^ b;
         ALUC_NOR:  r = ~(a | b);
         ALUC_LUI:  r = {b[15:0], 16'h0000};
         ALUC_SLTU: r = {31'b0, a < b};
         ALUC_SLT:  r = {31'b0, $signed(a) < $signed(b)};
         ALUC_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
         ALUC_SRL:  r = a >> b[4:0];
         ALUC_SLL:  r = a << b[4:0];
         default:   r = '0;
      endcase
      return {(r == 32'h0), c, r[31], v, r};
   endfunction

   logic [35:0] alu_out;
   assign alu_out = alu_ref(alu_a, alu_b, alu_aluc);
   assign {alu_zero, alu_carry, alu_negative, alu_overflow, alu_r} = alu_out;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: one pending op, visible to its owner from the second
   // cycle after acceptance until the owner takes it.
   logic        m_pend, m_owner, m_prio;
   int          m_age;
   logic [31:0] m_res, m_a, m_b;
   logic [3:0]  m_flg, m_op;
   logic        m_vis, m_win;
   int          m_g;

   assign m_vis = m_pend && (m_age >= 1);
   assign m_win = !rst && !flush &&
                  (!m_pend || (m_vis && (m_owner ? bus.rsp1_ready : bus.rsp0_ready)));
   assign m_g = !m_win ? -1 :
                (bus.req0_valid && bus.req1_valid) ? int'(m_prio) :
                bus.req0_valid ? 0 : bus.req1_valid ? 1 : -1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend  <= 1'b0;
         m_owner <= 1'b0;
         m_prio  <= INIT_PRIO;
         m_age   <= 0;
      end else if (m_g >= 0) begin
         m_pend  <= 1'b1;
         m_age   <= 0;
         m_owner <= (m_g == 1);
         m_prio  <= (m_g == 0);
         m_a     <= (m_g == 1) ? bus.req1_a : bus.req0_a;
         m_b     <= (m_g == 1) ? bus.req1_b : bus.req0_b;
         m_op    <= (m_g == 1) ? bus.req1_aluc : bus.req0_aluc;
         {m_flg, m_res} <= (m_g == 1) ? alu_ref(bus.req1_a, bus.req1_b, bus.req1_aluc)
                                      : alu_ref(bus.req0_a, bus.req0_b, bus.req0_aluc);
      end else if (flush || (m_vis && (m_owner ? bus.rsp1_ready : bus.rsp0_ready))) begin
         m_pend <= 1'b0;
      end else if (m_pend) begin
         m_age <= m_age + 1;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("req0_ready", bus.req0_ready, m_g == 0);
         chk("req1_ready", bus.req1_ready, m_g == 1);
         chk("rsp0_valid", bus.rsp0_valid, m_vis && !m_owner);
         chk("rsp1_valid", bus.rsp1_valid, m_vis && m_owner);
         if (m_vis) begin
            chk("rsp_r", bus.rsp_r, m_res);
            chk("rsp_flags", bus.rsp_flags, m_flg);
         end
         if (m_pend && m_age == 0) begin
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_aluc", alu_aluc, m_op);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
      flush = 1'b0;
   endtask

   task automatic drain();
      idle_inputs();
      repeat (3) cyc();
   endtask

   int grants[$];

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_aluc = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_aluc = '0;
      bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

      @(negedge clk);
      chk("rst_req0_ready", bus.req0_ready, 1'b0);
      chk("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
      chk("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
      chk("rst_rsp_r", bus.rsp_r, 32'h0);
      chk("rst_flags", bus.rsp_flags, 4'h0);
      chk("rst_alu_a", alu_a, 32'h0);
      cyc();
      rst = 1'b0;
      drain();

      // Single op on port 0: 5 - 3
      bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd3; bus.req0_aluc = ALUC_SUBU;
      @(negedge clk); chk("t1_req0_ready", bus.req0_ready, 1'b1);
      cyc(); bus.req0_valid = 1'b0;
      @(negedge clk); chk("t1_rsp0_early", bus.rsp0_valid, 1'b0);
      cyc();
      @(negedge clk);
      chk("t1_rsp0_valid", bus.rsp0_valid, 1'b1);
      chk("t1_rsp1_valid", bus.rsp1_valid, 1'b0);
      chk("t1_rsp_r", bus.rsp_r, 32'd2);
      chk("t1_zero", bus.rsp_flags[FLAG_ZERO], 1'b0);
      drain();

      // Signed overflow on port 1
      bus.req1_valid = 1'b1; bus.req1_a = 32'h7FFF_FFFF; bus.req1_b = 32'd1; bus.req1_aluc = ALUC_ADD;
      @(negedge clk); chk("t2_req1_ready", bus.req1_ready, 1'b1);
      cyc(); bus.req1_valid = 1'b0;
      cyc();
      @(negedge clk);
      chk("t2_rsp1_valid", bus.rsp1_valid, 1'b1);
      chk("t2_rsp0_valid", bus.rsp0_valid, 1'b0);
      chk("t2_rsp_r", bus.rsp_r, 32'h8000_0000);
      chk("t2_ovf", bus.rsp_flags[FLAG_OVF], 1'b1);
      chk("t2_neg", bus.rsp_flags[FLAG_NEG], 1'b1);
      drain();

      // Both ports continuously valid: grants alternate, one every 2 cycles
      bus.req0_valid = 1'b1; bus.req0_a = 32'd10; bus.req0_b = 32'd20; bus.req0_aluc = ALUC_ADD;
      bus.req1_valid = 1'b1; bus.req1_a = 32'hF0F0; bus.req1_b = 32'h0FF0; bus.req1_aluc = ALUC_XOR;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.req0_ready) grants.push_back(0);
         if (bus.req1_ready) grants.push_back(1);
         cyc();
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      chk("t3_grant_count", grants.size(), 4);
      for (int i = 0; i < grants.size(); i++) chk("t3_grant_order", grants[i], i % 2);
      drain();

      // Backpressure on rsp0 while req1 waits
      bus.rsp0_ready = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_a = 32'd100; bus.req0_b = 32'd7; bus.req0_aluc = ALUC_ADD;
      bus.req1_valid = 1'b1; bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 32'd1; bus.req1_aluc = ALUC_ADDU;
      @(negedge clk); chk("t4_req0_ready", bus.req0_ready, 1'b1);
      cyc(); bus.req0_valid = 1'b0;
      cyc();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", bus.rsp0_valid, 1'b1);
         chk("t4_hold_r", bus.rsp_r, 32'd107);
         chk("t4_hold_flags", bus.rsp_flags, 4'h0);
         chk("t4_req1_blocked", bus.req1_ready, 1'b0);
         cyc();
      end
      bus.rsp0_ready = 1'b1;
      @(negedge clk); chk("t4_req1_same_cycle", bus.req1_ready, 1'b1);
      cyc(); bus.req1_valid = 1'b0;
      cyc();
      @(negedge clk);
      chk("t4_rsp1_r", bus.rsp_r, 32'h0);
      chk("t4_rsp1_flags", bus.rsp_flags, 4'b1100);
      drain();

      // Flush during EXEC
      bus.req0_valid = 1'b1; bus.req0_a = 32'd9; bus.req0_b = 32'd9; bus.req0_aluc = ALUC_SUB;
      @(negedge clk); chk("t5_req0_ready", bus.req0_ready, 1'b1);
      cyc(); bus.req0_valid = 1'b0; flush = 1'b1;
      @(negedge clk); chk("t5_exec_no_rsp", bus.rsp0_valid, 1'b0);
      cyc(); flush = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_a = 32'd3; bus.req1_b = 32'd4; bus.req1_aluc = ALUC_SLT;
      @(negedge clk);
      chk("t5_idle_no_rsp", bus.rsp0_valid, 1'b0);
      chk("t5_req1_ready", bus.req1_ready, 1'b1);
      cyc(); bus.req1_valid = 1'b0;
      cyc();
      @(negedge clk);
      chk("t5_rsp1_valid", bus.rsp1_valid, 1'b1);
      chk("t5_rsp0_never", bus.rsp0_valid, 1'b0);
      chk("t5_rsp_r", bus.rsp_r, 32'd1);
      drain();

      // Async reset mid-RESP
      bus.rsp0_ready = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_a = 32'h1234; bus.req0_b = 32'd1; bus.req0_aluc = ALUC_ADD;
      cyc(); bus.req0_valid = 1'b0;
      cyc();
      @(negedge clk); chk("t6_pre_rsp0_valid", bus.rsp0_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_rsp0_valid", bus.rsp0_valid, 1'b0);
      chk("t6_rst_rsp_r", bus.rsp_r, 32'h0);
      chk("t6_rst_flags", bus.rsp_flags, 4'h0);
      chk("t6_rst_alu_a", alu_a, 32'h0);
      chk("t6_rst_alu_b", alu_b, 32'h0);
      cyc();
      rst = 1'b0;
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      @(negedge clk);
      chk("t6_init_prio_r0", bus.req0_ready, !INIT_PRIO);
      chk("t6_init_prio_r1", bus.req1_ready, INIT_PRIO);
      chk("t6_no_stale_rsp", bus.rsp0_valid, 1'b0);
      cyc(); bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      drain();
      repeat (2) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational ALU between two requesters: port 0 (execute stage) and port 1 (multi-cycle unit, e.g. mul/div sequencer). Round-robin arbitration and valid/ready handshakes on request and response sides. Operands are registered before reaching the ALU, and results and flags are registered before return. One operation is in flight at a time.

Parameters:
WIDTH, 32, operand/result width (ALU is 32-bit; only 32 is supported)
ALUC_W, 4, ALU opcode width
INIT_PRIO, 0, requester favoured by the first arbitration after reset (0 or 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
flush  input  1  synchronous; drops in-flight op and returns to IDLE
reqN_valid  input  1  (N=0,1) request present
reqN_ready  output  1  (N=0,1) request accepted this cycle when valid&ready
reqN_a  input  WIDTH  operand a
reqN_b  input  WIDTH  operand b
reqN_aluc  input  ALUC_W  ALU opcode
rspN_valid  output  1  result available for requester N
rspN_ready  input  1  requester N consumes result
rsp_r  output  WIDTH  shared result register
rsp_flags  output  4  {zero, carry, negative, overflow}, shared
alu_a  output  WIDTH  to ALU a
alu_b  output  WIDTH  to ALU b
alu_aluc  output  ALUC_W  to ALU aluc
alu_r  input  WIDTH  from ALU r
alu_zero, alu_carry, alu_negative, alu_overflow  input  1 each  ALU flags

Behaviour:
- States: IDLE, EXEC, RESP. Registers: op_a, op_b, op_aluc, owner (1 bit), prio (1 bit), rsp_r, rsp_flags.
- Reset (async): state=IDLE; prio=INIT_PRIO; owner=0; op_*, rsp_r and rsp_flags=0; all ready/valid outputs=0; alu_* outputs=0.
- Grant: a grant is possible in IDLE, and in RESP in the same cycle the current owner's rspN_ready is high. If one requester is valid, it is granted. If both are valid, prio is granted. reqN_ready=1 only for the granted requester, and is combinational from reqN_valid, rspN_ready and state.
- On grant: capture a, b and aluc into op_*; owner=granted; prio=~granted; next state=EXEC.
- EXEC, exactly 1 cycle: alu_a=op_a, alu_b=op_b, alu_aluc=op_aluc. Capture alu_r and the four flags into rsp_* at the end of the cycle. Next state=RESP.
- alu_* outputs are driven from op_* in every state. Operands are therefore stable to the ALU for the whole op, with no glitch between ops.
- RESP: rsp{owner}_valid=1 and the other rsp valid=0. Hold rsp_r and rsp_flags stable until rspN_ready. On handshake: grant as above (-> EXEC) or go to IDLE.
- Latency: accept at cycle T, result valid at T+2. Sustained throughput is 1 op / 2 cycles with rsp_ready tied high.
- Flags: carry and overflow are captured exactly as the ALU presents them. They are not meaningful for opcodes that leave them unwritten, and the requester ignores them for those opcodes.
- flush: from any state, next state=IDLE and no grant is given that cycle (reqN_ready=0). rsp valids drop the next cycle. prio is unchanged unless a grant already happened.
- flush and rsp handshake in the same cycle: flush wins; no new grant.
- rst asserted mid-op: op is discarded and no response is issued.
- reqN_valid deasserted before ready: permitted; nothing is captured.
- rspN_valid is never asserted for a requester that did not own the op.

Decomposition:
- Shared package alu_pkg: ALU opcode constants (ADDU=4'b0000, SUBU=4'b0001, ADD=4'b0010, SUB=4'b0011, AND=4'b0100, OR=4'b0101, XOR=4'b0110, NOR=4'b0111, LUI=4'b1000, SLTU=4'b1010, SLT=4'b1011, SRA=4'b1100, SRL=4'b1101, SLL=4'b1110), flag bit indices, state encoding.
- One sub-module, rr_arb2: 2-way round-robin grant logic (valid0, valid1, prio -> grant0, grant1). The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- Single op on port 0: a=5, b=3, aluc=0001, rsp_ready=1. Response: req0_ready at T, rsp0_valid at T+2 with rsp_r=2 and zero=0. rsp1_valid stays 0.
- Signed overflow on port 1: a=0x7FFFFFFF, b=1, aluc=0010. Response: rsp_r=0x80000000, overflow=1, negative=1.
- Both ports valid continuously, INIT_PRIO=0, rsp_ready high. Response: grants alternate 0,1,0,1; one rsp every 2 cycles; owner order matches grant order.
- Backpressure: rsp0_ready held low for 5 cycles. Response: rsp0_valid, rsp_r and rsp_flags stable across those cycles. req1 is not granted until the rsp0 handshake, then is granted in that same cycle.
- flush asserted during EXEC. Response: IDLE next cycle, no rsp valid ever issued for the op, and the next request is accepted normally.
- Async rst pulse mid-RESP, between clock edges. Response: all outputs 0 immediately; after release, the first contended grant goes to INIT_PRIO.
